// File: rtl/ika9958_pkg.sv
// Shared types and constants for the IKA9958 VRAM slot scheduler.
package ika9958_pkg;

  localparam int unsigned SLOT_W    = 3;
  localparam int unsigned STARVE_W  = 3;
  localparam int unsigned OWNER_N   = 4;
  localparam int unsigned REF_ROW_W = 8;

  // Bit n set means display owns slot n while the fetch window is active.
  localparam logic [7:0] DISP_SLOT_MASK = 8'b1110_1110;

  typedef enum logic [1:0] {
    OWN_REF  = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_CMD  = 2'd3
  } owner_e;

  typedef logic [SLOT_W-1:0] slot_t;

  function automatic logic [OWNER_N-1:0] owner_onehot(input owner_e o);
    return OWNER_N'(4'b0001 << o);
  endfunction

endpackage

// File: rtl/ika9958_vram_freeslot_pick.sv
// Free-slot arbitration between CPU and command engine, with the
// command-engine starvation counter update.
module ika9958_vram_freeslot_pick
  import ika9958_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic                free,
  input  logic                cpu_req,
  input  logic                cmd_req,
  input  logic [STARVE_W-1:0] starve,
  output logic                cpu_win_c,
  output logic                cmd_win_c,
  output logic [STARVE_W-1:0] starve_nxt_c
);

  logic starved_c;

  always_comb begin
    cpu_win_c    = 1'b0;
    cmd_win_c    = 1'b0;
    starve_nxt_c = starve;
    starved_c    = (starve >= STARVE_W'(STARVE_MAX));
    if (free) begin
      if (cpu_req && cmd_req) begin
        if (starved_c) begin
          cmd_win_c    = 1'b1;
          starve_nxt_c = '0;
        end else begin
          cpu_win_c    = 1'b1;
          // Saturate so a long CPU burst cannot wrap the counter back to 0.
          starve_nxt_c = (starve == '1) ? starve : starve + STARVE_W'(1);
        end
      end else if (cpu_req) begin
        cpu_win_c = 1'b1;
      end else if (cmd_req) begin
        cmd_win_c    = 1'b1;
        starve_nxt_c = '0;
      end
    end
  end

endmodule

// File: rtl/ika9958_vram_slot_arb.sv
// VRAM access-slot scheduler: 8-slot window, fixed refresh/display slots,
// CPU/CMD arbitration of free slots. Refresh is enabled by IKA9958_VRAM_REFRESH_EN.
module ika9958_vram_slot_arb
  import ika9958_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic                 i_phiA,
  input  logic                 i_RST_n,
  input  logic                 i_phiA_NCEN,
  input  logic                 i_phiL_PCEN,
  input  logic                 i_phiL_NCEN,
  input  logic                 i_DISP_ACT,
  input  logic                 i_CPU_REQ,
  input  logic                 i_CMD_REQ,
  output logic [OWNER_N-1:0]   o_GNT,
  output logic [OWNER_N-1:0]   o_ACK,
  output logic [SLOT_W-1:0]    o_SLOT,
  output logic [REF_ROW_W-1:0] o_REF_ROW
);

  slot_t                slot_q;
  slot_t                slot_nxt_c;
  logic [STARVE_W-1:0]  starve_q;
  logic [STARVE_W-1:0]  starve_nxt_c;
  logic [OWNER_N-1:0]   gnt_q;
  logic [OWNER_N-1:0]   ack_q;
  logic [OWNER_N-1:0]   gnt_nxt_c;
  logic                 ref_slot_c;
  logic                 disp_slot_c;
  logic                 free_c;
  logic                 cpu_win_c;
  logic                 cmd_win_c;

  // Ownership decode for the slot about to start.
  always_comb begin
    slot_nxt_c  = slot_q + SLOT_W'(1);
    disp_slot_c = i_DISP_ACT && DISP_SLOT_MASK[slot_nxt_c];
`ifdef IKA9958_VRAM_REFRESH_EN
    ref_slot_c  = (slot_nxt_c == SLOT_W'(0));
`else
    ref_slot_c  = 1'b0;
`endif
    free_c      = !ref_slot_c && !disp_slot_c;
  end

  ika9958_vram_freeslot_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .free         (free_c),
    .cpu_req      (i_CPU_REQ),
    .cmd_req      (i_CMD_REQ),
    .starve       (starve_q),
    .cpu_win_c    (cpu_win_c),
    .cmd_win_c    (cmd_win_c),
    .starve_nxt_c (starve_nxt_c)
  );

  always_comb begin
    gnt_nxt_c = '0;
    if (ref_slot_c) begin
      gnt_nxt_c = owner_onehot(OWN_REF);
    end else if (disp_slot_c) begin
      gnt_nxt_c = owner_onehot(OWN_DISP);
    end else if (cpu_win_c) begin
      gnt_nxt_c = owner_onehot(OWN_CPU);
    end else if (cmd_win_c) begin
      gnt_nxt_c = owner_onehot(OWN_CMD);
    end
  end

  // Slot start loads the new grant; slot end echoes it as a one-tick ack.
  always_ff @(posedge i_phiA or negedge i_RST_n) begin
    if (!i_RST_n) begin
      slot_q   <= SLOT_W'(7);
      gnt_q    <= '0;
      ack_q    <= '0;
      starve_q <= '0;
    end else if (i_phiA_NCEN) begin
      if (i_phiL_PCEN) begin
        slot_q   <= slot_nxt_c;
        gnt_q    <= gnt_nxt_c;
        starve_q <= starve_nxt_c;
        ack_q    <= '0;
      end else if (i_phiL_NCEN) begin
        ack_q <= gnt_q;
      end else begin
        ack_q <= '0;
      end
    end
  end

  assign o_SLOT = slot_q;
  assign o_GNT  = gnt_q;
  assign o_ACK  = ack_q;

`ifdef IKA9958_VRAM_REFRESH_EN
  logic [REF_ROW_W-1:0] ref_row_q;

  always_ff @(posedge i_phiA or negedge i_RST_n) begin
    if (!i_RST_n) begin
      ref_row_q <= '0;
    end else if (i_phiA_NCEN && !i_phiL_PCEN && i_phiL_NCEN && gnt_q[OWN_REF]) begin
      ref_row_q <= ref_row_q + REF_ROW_W'(1);
    end
  end

  assign o_REF_ROW = ref_row_q;
`else
  assign o_REF_ROW = '0;
`endif

endmodule

// File: tb/tb_ika9958_vram_slot_arb.sv
// Bench for ika9958_vram_slot_arb: table-driven windows, hand sequences for
// request drop and mid-slot reset, then random slots against a rule-level model.
module tb_ika9958_vram_slot_arb;

  localparam int unsigned STARVE_MAX = 2;
`ifdef IKA9958_VRAM_REFRESH_EN
  localparam bit REF_EN = 1'b1;
`else
  localparam bit REF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       phia_ncen, phil_pcen, phil_ncen;
  logic       disp_act, cpu_req, cmd_req;
  logic [3:0] gnt, ack;
  logic [2:0] slot;
  logic [7:0] ref_row;

  ika9958_vram_slot_arb #(.STARVE_MAX(STARVE_MAX)) dut (
    .i_phiA      (clk),
    .i_RST_n     (rst_n),
    .i_phiA_NCEN (phia_ncen),
    .i_phiL_PCEN (phil_pcen),
    .i_phiL_NCEN (phil_ncen),
    .i_DISP_ACT  (disp_act),
    .i_CPU_REQ   (cpu_req),
    .i_CMD_REQ   (cmd_req),
    .o_GNT       (gnt),
    .o_ACK       (ack),
    .o_SLOT      (slot),
    .o_REF_ROW   (ref_row)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       disp;
    logic       cpu;
    logic       cmd;
    logic [3:0] exp_gnt;
  } vec_t;

  vec_t tbl[25];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: slot number, starve count, refresh row.
  int m_slot;
  int m_starve;
  int m_ref;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int model_owner(input int s, input logic d, input logic c, input logic m);
    int own = -1;
    if (REF_EN && s == 0) own = 0;
    else if (d && s != 0 && s != 4) own = 1;
    else if (c && m) begin
      if (m_starve >= int'(STARVE_MAX)) begin
        own = 3;
        m_starve = 0;
      end else begin
        own = 2;
        if (m_starve < 7) m_starve++;
      end
    end else if (c) own = 2;
    else if (m) begin
      own = 3;
      m_starve = 0;
    end
    return own;
  endfunction

  // One full slot: 8 phiA cycles, 4 phiA_NCEN ticks, PCEN on tick 0, NCEN on tick 2.
  task automatic run_slot(input logic d, input logic c, input logic m, input logic drop,
                          input int abort_c, input logic use_tbl, input logic [3:0] tbl_exp);
    int         own;
    logic [3:0] eg;
    bit         aborted = 0;
    for (int cy = 0; cy < 8; cy++) begin
      @(negedge clk);
      phia_ncen = (cy % 2 == 0);
      phil_pcen = (cy == 0);
      phil_ncen = (cy == 4);
      if (cy == 0) begin
        disp_act = d;
        cpu_req  = c;
        cmd_req  = m;
      end
      if (cy == 1 && drop) cpu_req = 1'b0;
      if (cy == abort_c) begin
        rst_n = 1'b0;
        #1;
        chk("abort_gnt", 8'(gnt), 8'h0);
        chk("abort_ack", 8'(ack), 8'h0);
        chk("abort_slot", 8'(slot), 8'd7);
        chk("abort_ref", ref_row, 8'h0);
        m_slot = 7;
        m_starve = 0;
        m_ref = 0;
        aborted = 1;
      end
      if (cy == 7 && aborted) rst_n = 1'b1;
      @(posedge clk);
      #1;
      if (cy == 0) begin
        m_slot = (m_slot + 1) % 8;
        own = model_owner(m_slot, d, c, m);
        eg = (own < 0) ? 4'h0 : 4'(1 << own);
        chk("slot", 8'(slot), 8'(m_slot));
        chk("gnt", 8'(gnt), 8'(eg));
        chk("ack_at_start", 8'(ack), 8'h0);
        if (use_tbl) chk("tbl_gnt", 8'(gnt), 8'(tbl_exp));
      end
      if (cy == 4) begin
        if (aborted) chk("ack_after_abort", 8'(ack), 8'h0);
        else begin
          chk("ack", 8'(ack), 8'(eg));
          if (own == 0) m_ref = (m_ref + 1) % 256;
        end
      end
      if (cy == 6) begin
        chk("ack_clear", 8'(ack), 8'h0);
        chk("gnt_held", 8'(gnt), aborted ? 8'h0 : 8'(eg));
        chk("ref_row", ref_row, 8'(m_ref));
      end
    end
  endtask

  initial begin
    logic [3:0] pat_ref [9];
    logic [3:0] pat_nref[9];
    logic d, c, m, dr;
    pat_ref  = '{4'h1, 4'h4, 4'h4, 4'h8, 4'h4, 4'h4, 4'h8, 4'h4, 4'h1};
    pat_nref = '{4'h4, 4'h4, 4'h8, 4'h4, 4'h4, 4'h8, 4'h4, 4'h4, 4'h8};
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b0, (i == 0 && REF_EN) ? 4'h1 : 4'h0};
    for (int i = 0; i < 8; i++)
      tbl[8+i] = '{1'b1, 1'b1, 1'b0,
                   (i == 0) ? (REF_EN ? 4'h1 : 4'h4) : (i == 4) ? 4'h4 : 4'h2};
    for (int i = 0; i < 9; i++)
      tbl[16+i] = '{1'b0, 1'b1, 1'b1, REF_EN ? pat_ref[i] : pat_nref[i]};

    rst_n = 1'b0;
    phia_ncen = 1'b0;
    phil_pcen = 1'b0;
    phil_ncen = 1'b0;
    disp_act = 1'b0;
    cpu_req = 1'b0;
    cmd_req = 1'b0;
    m_slot = 7;
    m_starve = 0;
    m_ref = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_slot", 8'(slot), 8'd7);
    chk("rst_gnt", 8'(gnt), 8'h0);
    chk("rst_ack", 8'(ack), 8'h0);
    chk("rst_ref", ref_row, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++)
      run_slot(tbl[i].disp, tbl[i].cpu, tbl[i].cmd, 1'b0, -1, 1'b1, tbl[i].exp_gnt);

    // Slot 1: CPU drops its request right after winning; grant and ack still stand.
    run_slot(1'b0, 1'b1, 1'b0, 1'b1, -1, 1'b1, 4'h4);
    // Slot 2: CMD granted, then reset mid-slot before its ack.
    run_slot(1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 4'h8);
    // First slot after release is slot 0.
    run_slot(1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b1, REF_EN ? 4'h1 : 4'h4);

    for (int i = 0; i < 160; i++) begin
      d  = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      m  = 1'($urandom_range(0, 1));
      dr = c && ($urandom_range(0, 3) == 0);
      run_slot(d, c, m, dr, -1, 1'b0, 4'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ika9958_vram_slot_arb.md
# ika9958_vram_slot_arb

VRAM access-slot scheduler for IKA9958. Divides VRAM bandwidth into fixed slots, one per phiL period (5.37 MHz). Each slot goes to one of four requesters:
- refresh
- display fetch
- CPU port
- command engine

It runs off the internal master clock and the phiL clock enables from reset/clock control, and issues one-hot grants plus slot-end acknowledges to the VRAM sequencer and requesters.

## Interface
Parameters:
- STARVE_MAX, default 2: consecutive free slots the command engine may lose to the CPU before it gets forced priority (range 1..7).

Ports:
- i_phiA  input  1  internal master clock; all flops use posedge.
- i_RST_n  input  1  reset; asynchronous, active-low.
- i_phiA_NCEN  input  1  21.48 MHz clock enable; all flops hold when low.
- i_phiL_PCEN  input  1  slot-start enable; already qualified with phiA_NCEN.
- i_phiL_NCEN  input  1  slot-end enable; already qualified with phiA_NCEN.
- i_DISP_ACT  input  1  display fetch window active for the current line.
- i_CPU_REQ  input  1  CPU access request; level, held until ack.
- i_CMD_REQ  input  1  command engine request; level, held until ack.
- o_GNT  output  4  one-hot slot owner {CMD,CPU,DISP,REF}; all-zero means idle slot.
- o_ACK  output  4  one-tick pulse per owner at slot end.
- o_SLOT  output  3  current slot index 0..7.
- o_REF_ROW  output  8  refresh row address.

## Operation
- An 8-slot window repeats continuously.
- Slot counter increments modulo 8 on each i_phiL_PCEN.
- Fixed slot ownership:
  - Slot 0 is refresh.
  - When i_DISP_ACT is high, slots 1,2,3,5,6,7 are display.
  - When i_DISP_ACT is low, slots 1–7 are free.
  - Slot 4 is always free.
- i_DISP_ACT is sampled at i_phiL_PCEN. A change mid-slot takes effect at the next slot.
- Free-slot policy:
  - If only one of CPU/CMD requests, it wins.
  - If both request, CPU wins unless the starve counter is ≥ STARVE_MAX; then CMD wins.
  - If neither requests, o_GNT = 0.
- Starve counter (3 bits):
  - Increments (saturating at 7) when CMD requested in a free slot but CPU won.
  - Clears when CMD is granted.
  - Otherwise holds.
- Requests are sampled only at i_phiL_PCEN.
- Grant is held for the whole slot, even if the request drops mid-slot. Ack still fires; there is no abort.
- At i_phiL_NCEN, o_ACK = o_GNT for one phiA_NCEN tick, then returns to 0.
- A requester must drop its request on the tick after its ack, or it is treated as a new request.
- o_REF_ROW increments (wrapping 255→0) on each refresh ack.

## Timing
- Reset values:
  - o_SLOT = 7, so the first slot after reset is 0.
  - o_GNT = 0, o_ACK = 0, o_REF_ROW = 0, starve counter = 0.
- Reset asserted mid-slot clears everything immediately, with no ack for the aborted slot. The first grant follows the first i_phiL_PCEN after release.
- Grant latency: o_GNT and o_SLOT are registered and update on the phiA edge where i_phiL_PCEN is high.
- Request setup: a request must be high on that same edge to win the slot. A request rising later waits for the next slot.
- Ack: registered, high for exactly the phiA_NCEN tick following the edge where i_phiL_NCEN is high, within the same slot.
- Worst-case CPU wait with display active is 8 slots (slot 4 of the next window). When display and CMD starvation coincide, it is 16 slots.
- If i_phiL_PCEN and i_phiL_NCEN are both high, PCEN wins and no ack fires. This cannot happen with a legal clock divider.

## Configuration
- IKA9958_VRAM_REFRESH_EN defined:
  - Slot 0 is refresh.
  - o_GNT[0]/o_ACK[0] are active.
  - o_REF_ROW counts.
- Not defined:
  - Slot 0 is a free slot.
  - o_GNT[0] and o_ACK[0] are tied 0.
  - o_REF_ROW is tied 0 and the row counter is removed.

## Structure
- Shared package ika9958_pkg holds:
  - the owner enum (REF=0, DISP=1, CPU=2, CMD=3)
  - the 3-bit slot index type
  - localparam DISP_SLOT_MASK = 8'b1110_1110 (bit n set means display owns slot n)
- One sub-module, ika9958_vram_freeslot_pick: combinational CPU/CMD choice plus starve counter update.
- The top level holds:
  - the slot counter
  - the ownership decode
  - the grant/ack registers
  - the refresh row counter

## Test plan
- Reset release, no requests, i_DISP_ACT = 0 → o_SLOT cycles 0..7. Grant {REF} only in slot 0, otherwise 0. o_REF_ROW = 1 after the first slot-0 ack.
- i_DISP_ACT = 1, CPU requests continuously → CPU is granted only in slot 4. DISP is granted in slots 1,2,3,5,6,7.
- i_DISP_ACT = 0, CPU and CMD both request continuously, STARVE_MAX = 2 → free-slot owners follow the pattern CPU,CPU,CMD repeating.
- CPU request drops one tick after i_phiL_PCEN → grant is held, and o_ACK[2] still pulses once at i_phiL_NCEN.
- Reset asserted mid-slot while CMD is granted → o_GNT = 0 immediately, with no ack. After release, slot 0 comes first.
- Build without IKA9958_VRAM_REFRESH_EN, CPU requesting → CPU is granted in slot 0. o_REF_ROW stays 0.
